// File: rtl/wire_select_sequencer_pkg.sv
// Shared definitions for the wire select sequencer.
//   wire_seq_state_t : sequencer operating states (LOAD, DRAIN, READY, RUN)
//   SELECTS_PER_STEP : number of select fields per program step (a, b, c)
//   step_width()     : packed width of one program step for a given select width
package wire_select_sequencer_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        DRAIN = 2'd1,
        READY = 2'd2,
        RUN   = 2'd3
    } wire_seq_state_t;

    localparam int unsigned SELECTS_PER_STEP = 3;

    function automatic int unsigned step_width(input int unsigned choice_width);
        return SELECTS_PER_STEP * choice_width;
    endfunction

endpackage

// File: rtl/wire_select_program_ram.sv
// Program buffer for the wire select sequencer: simple dual-port memory with a
// synchronous write port and a registered read port. Contents are not reset.
// Ports:
//   clk    in  clock
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data (one packed select triple)
//   re     in  read enable; rdata updates only when high
//   raddr  in  read address
//   rdata  out registered read data
module wire_select_program_ram #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned WIDTH      = 6,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/wire_select_sequencer.sv
// Wire select sequencer: loads a gate program (one {a,b,c} select triple per
// step) from an AXI-Stream slave, then replays it one step per cycle on start.
// The program is retained after a run and can be replayed without reloading.
// Optional feature macro: WIRE_SELECT_CHECK_EN -- when defined, beats with an
// out-of-range select or with two equal selects are accepted but not stored,
// and set the sticky error flag.
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   s_axis_tdata       packed {a_sel, b_sel, c_sel}, a_sel in the MSBs
//   s_axis_tvalid/tready/tlast  program load stream
//   reload             pulse: discard program and return to loading
//   start              pulse: replay stored program
//   busy, step_valid   high while steps are emitted
//   step_last          marks the final step of a run
//   a/b/c_select       current step's selects (held when step_valid is low)
//   program_length     number of stored steps
//   error              sticky error, cleared by reset or reload
module wire_select_sequencer
    import wire_select_sequencer_pkg::*;
#(
    parameter int unsigned NUMBER_OF_INPUT_WIRES = 4,
    parameter int unsigned CHOICE_WIDTH          = $clog2(NUMBER_OF_INPUT_WIRES),
    parameter int unsigned PROGRAM_DEPTH         = 16,
    parameter int unsigned ADDR_WIDTH            = $clog2(PROGRAM_DEPTH)
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    input  logic [SELECTS_PER_STEP*CHOICE_WIDTH-1:0] s_axis_tdata,
    input  logic                                   s_axis_tvalid,
    output logic                                   s_axis_tready,
    input  logic                                   s_axis_tlast,
    input  logic                                   reload,
    input  logic                                   start,
    output logic                                   busy,
    output logic                                   step_valid,
    output logic                                   step_last,
    output logic [CHOICE_WIDTH-1:0]                a_select,
    output logic [CHOICE_WIDTH-1:0]                b_select,
    output logic [CHOICE_WIDTH-1:0]                c_select,
    output logic [ADDR_WIDTH:0]                    program_length,
    output logic                                   error
);

    localparam int unsigned STEP_WIDTH = step_width(CHOICE_WIDTH);
    localparam int unsigned LEN_WIDTH  = ADDR_WIDTH + 1;

    localparam logic [1:0] ST_LOAD  = 2'(LOAD);
    localparam logic [1:0] ST_DRAIN = 2'(DRAIN);
    localparam logic [1:0] ST_READY = 2'(READY);
    localparam logic [1:0] ST_RUN   = 2'(RUN);

    localparam logic [LEN_WIDTH-1:0] FULL_COUNT = LEN_WIDTH'(PROGRAM_DEPTH);
    localparam logic [LEN_WIDTH-1:0] LAST_SLOT  = LEN_WIDTH'(PROGRAM_DEPTH - 1);
    localparam logic [LEN_WIDTH-1:0] ONE        = LEN_WIDTH'(1);

    logic [1:0]            state_q, state_d;
    logic [LEN_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LEN_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LEN_WIDTH-1:0]  length_q, length_d;
    logic                  error_q, error_d;
    logic                  step_last_q, step_last_d;
    logic                  tready_q, tready_d;
    logic [STEP_WIDTH-1:0] hold_q;

    logic                  beat;
    logic                  beat_ok;
    logic                  ram_we;
    logic                  ram_re;
    logic [ADDR_WIDTH-1:0] ram_raddr;
    logic [STEP_WIDTH-1:0] ram_rdata;
    logic [STEP_WIDTH-1:0] sel_word;

    assign beat = s_axis_tvalid & tready_q;

`ifdef WIRE_SELECT_CHECK_EN
    logic [CHOICE_WIDTH-1:0] in_a, in_b, in_c;

    assign in_a = s_axis_tdata[3*CHOICE_WIDTH-1:2*CHOICE_WIDTH];
    assign in_b = s_axis_tdata[2*CHOICE_WIDTH-1:CHOICE_WIDTH];
    assign in_c = s_axis_tdata[CHOICE_WIDTH-1:0];

    assign beat_ok = (32'(in_a) < NUMBER_OF_INPUT_WIRES) &&
                     (32'(in_b) < NUMBER_OF_INPUT_WIRES) &&
                     (32'(in_c) < NUMBER_OF_INPUT_WIRES) &&
                     (in_a != in_b) && (in_b != in_c) && (in_a != in_c);
`else
    assign beat_ok = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        length_d    = length_q;
        error_d     = error_q;
        step_last_d = step_last_q;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        ram_raddr   = rd_ptr_q[ADDR_WIDTH-1:0];

        unique case (state_q)
            ST_LOAD: begin
                if (reload) begin
                    wr_ptr_d = '0;
                    length_d = '0;
                    error_d  = 1'b0;
                end else if (beat) begin
                    if (beat_ok) begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + ONE;
                    end else begin
                        error_d = 1'b1;
                    end
                    if (s_axis_tlast) begin
                        // Rejected beats are not counted; an empty program keeps loading.
                        length_d = wr_ptr_d;
                        if (wr_ptr_d != '0) begin
                            state_d = ST_READY;
                        end
                    end else if (beat_ok && (wr_ptr_q == LAST_SLOT)) begin
                        error_d  = 1'b1;
                        length_d = FULL_COUNT;
                        state_d  = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (reload) begin
                    state_d  = ST_LOAD;
                    wr_ptr_d = '0;
                    length_d = '0;
                    error_d  = 1'b0;
                end else if (beat && s_axis_tlast) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (reload) begin
                    state_d  = ST_LOAD;
                    wr_ptr_d = '0;
                    length_d = '0;
                    error_d  = 1'b0;
                end else if (start) begin
                    // Issue the read of step 0 now so it appears the next cycle.
                    state_d     = ST_RUN;
                    ram_re      = 1'b1;
                    ram_raddr   = '0;
                    rd_ptr_d    = ONE;
                    step_last_d = (length_q == ONE);
                end
            end
            ST_RUN: begin
                if (step_last_q) begin
                    state_d     = ST_READY;
                    step_last_d = 1'b0;
                end else begin
                    // rd_ptr_q is the index of the step that appears next cycle.
                    ram_re      = 1'b1;
                    ram_raddr   = rd_ptr_q[ADDR_WIDTH-1:0];
                    rd_ptr_d    = rd_ptr_q + ONE;
                    step_last_d = ((rd_ptr_q + ONE) == length_q);
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

        tready_d = (state_d == ST_LOAD) || (state_d == ST_DRAIN);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_LOAD;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            length_q    <= '0;
            error_q     <= 1'b0;
            step_last_q <= 1'b0;
            tready_q    <= 1'b0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            length_q    <= length_d;
            error_q     <= error_d;
            step_last_q <= step_last_d;
            tready_q    <= tready_d;
            if (step_valid) begin
                hold_q <= ram_rdata;
            end
        end
    end

    wire_select_program_ram #(
        .DEPTH      (PROGRAM_DEPTH),
        .WIDTH      (STEP_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_program_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata (s_axis_tdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // The read register is not reset, so outside a run the selects come from hold_q.
    assign sel_word = step_valid ? ram_rdata : hold_q;

    assign s_axis_tready  = tready_q;
    assign busy           = (state_q == ST_RUN);
    assign step_valid     = (state_q == ST_RUN);
    assign step_last      = step_last_q;
    assign a_select       = sel_word[3*CHOICE_WIDTH-1:2*CHOICE_WIDTH];
    assign b_select       = sel_word[2*CHOICE_WIDTH-1:CHOICE_WIDTH];
    assign c_select       = sel_word[CHOICE_WIDTH-1:0];
    assign program_length = length_q;
    assign error          = error_q;

endmodule

// File: tb/tb_wire_select_sequencer.sv
// Self-checking bench for wire_select_sequencer (4 wires, 16-step program).
module tb_wire_select_sequencer;

    localparam int NW = 4;
    localparam int PD = 16;
`ifdef WIRE_SELECT_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [5:0] s_axis_tdata = '0;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic       s_axis_tlast = 1'b0;
    logic       reload = 1'b0;
    logic       start = 1'b0;
    logic       busy;
    logic       step_valid;
    logic       step_last;
    logic [1:0] a_select;
    logic [1:0] b_select;
    logic [1:0] c_select;
    logic [4:0] program_length;
    logic       error;

    wire_select_sequencer #(
        .NUMBER_OF_INPUT_WIRES (NW),
        .PROGRAM_DEPTH         (PD)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .reload         (reload),
        .start          (start),
        .busy           (busy),
        .step_valid     (step_valid),
        .step_last      (step_last),
        .a_select       (a_select),
        .b_select       (b_select),
        .c_select       (c_select),
        .program_length (program_length),
        .error          (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] word;
        logic       last;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail = 0;

    // Reference model: stored program, sticky error, phase (0 load, 1 drain, 2 ready).
    logic [5:0] m_prog[$];
    bit         m_err;
    int         m_state;
    logic [5:0] stim[$];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic bit model_ok(input logic [5:0] d);
        int a, b, c;
        a = int'(d[5:4]);
        b = int'(d[3:2]);
        c = int'(d[1:0]);
        return !CHECK_EN || (a < NW && b < NW && c < NW && a != b && b != c && a != c);
    endfunction

    task automatic model_reset();
        m_prog.delete();
        m_err   = 1'b0;
        m_state = 0;
    endtask

    task automatic model_beat(input logic [5:0] d, input bit last);
        bit ok;
        ok = model_ok(d);
        if (m_state == 0) begin
            if (ok) m_prog.push_back(d);
            else m_err = 1'b1;
            if (last) begin
                if (m_prog.size() > 0) m_state = 2;
            end else if (ok && m_prog.size() == PD) begin
                m_err   = 1'b1;
                m_state = 1;
            end
        end else if (m_state == 1) begin
            if (last) m_state = 2;
        end
    endtask

    // Scoreboard monitor: every presented step is popped and compared.
    always @(negedge clk) begin
        exp_t e;
        if (step_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_step: got a/b/c %0d/%0d/%0d, expected no step (t=%0t)",
                         a_select, b_select, c_select, $time);
            end else begin
                e = sb.pop_front();
                check("step_a", a_select, int'(e.word[5:4]));
                check("step_b", b_select, int'(e.word[3:2]));
                check("step_c", c_select, int'(e.word[1:0]));
                check("step_last", step_last, int'(e.last));
            end
        end else begin
            check("idle_last", step_last, 0);
        end
    end

    task automatic check_status(input string tag);
        check({tag, "_length"}, program_length, m_prog.size());
        check({tag, "_error"}, error, int'(m_err));
        check({tag, "_tready"}, s_axis_tready, int'(m_state != 2));
    endtask

    task automatic send_beat(input logic [5:0] d, input bit last);
        int n = 0;
        @(negedge clk);
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("beat_tready", s_axis_tready, 1);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (n < 20) model_beat(d, last);
    endtask

    task automatic load_stim(input string tag);
        foreach (stim[i]) send_beat(stim[i], i == stim.size() - 1);
        @(negedge clk);
        check_status(tag);
    endtask

    task automatic do_reload();
        @(negedge clk);
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        model_reset();
    endtask

    task automatic run_check(input bit poke, input bit chained_in, input bit chain_out);
        int         len;
        logic [5:0] final_word;
        len = m_prog.size();
        foreach (m_prog[i]) sb.push_back('{m_prog[i], i == len - 1});
        if (!chained_in) begin
            @(negedge clk);
            start = 1'b1;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            check("run_valid", step_valid, 1);
            check("run_busy", busy, 1);
            if (poke && k == 1) begin
                start  = 1'b1;
                reload = 1'b1;
            end
            @(posedge clk);
            #1;
            start  = 1'b0;
            reload = 1'b0;
        end
        if (chain_out) start = 1'b1;
        @(negedge clk);
        check("end_valid", step_valid, 0);
        check("end_busy", busy, 0);
        check("end_queue", sb.size(), 0);
        final_word = m_prog[len - 1];
        check("hold_a", a_select, int'(final_word[5:4]));
        check("hold_c", c_select, int'(final_word[1:0]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tries;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tready", s_axis_tready, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", step_valid, 0);
        check("rst_last", step_last, 0);
        check("rst_a", a_select, 0);
        check("rst_b", b_select, 0);
        check("rst_c", c_select, 0);
        check("rst_length", program_length, 0);
        check("rst_error", error, 0);
        resetn = 1'b1;
        @(negedge clk);
        check("post_rst_tready", s_axis_tready, 1);

        // Three-step program, replay, then back-to-back replays
        stim = '{6'h06, 6'h1B, 6'h24};
        load_stim("three");
        run_check(1'b0, 1'b0, 1'b0);
        run_check(1'b0, 1'b0, 1'b1);
        run_check(1'b0, 1'b1, 1'b0);

        // One-beat program
        do_reload();
        stim = '{6'h39};
        load_stim("one");
        run_check(1'b0, 1'b0, 1'b0);

        // Overflow: 20 beats, only the first 16 kept
        do_reload();
        stim.delete();
        for (int i = 0; i < 20; i++) stim.push_back(6'(i * 7 + 3));
        load_stim("overflow");
        run_check(1'b0, 1'b0, 1'b0);

        // start/reload during a run are ignored
        run_check(1'b1, 1'b0, 1'b0);
        check_status("after_poke");

        // reload and start together in READY: reload wins
        @(negedge clk);
        reload = 1'b1;
        start  = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        start  = 1'b0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check("reload_win_valid", step_valid, 0);
        end
        check_status("reload_win");

        // Reset in the middle of a run
        stim = '{6'h06, 6'h1B, 6'h24};
        load_stim("pre_reset");
        foreach (m_prog[i]) sb.push_back('{m_prog[i], i == m_prog.size() - 1});
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", step_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_last", step_last, 0);
        check("mid_rst_a", a_select, 0);
        check("mid_rst_b", b_select, 0);
        check("mid_rst_c", c_select, 0);
        check("mid_rst_length", program_length, 0);
        check("mid_rst_error", error, 0);
        check("mid_rst_pending", sb.size(), 1);
        sb.delete();
        model_reset();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("ignored_start_valid", step_valid, 0);
        end
        check_status("after_mid_rst");

        // Beat validation (stored verbatim unless checking is built in)
        stim = '{6'h05, 6'h06};
        load_stim("checked");
        if (m_state == 2) run_check(1'b0, 1'b0, 1'b0);

        // Randomized programs
        for (int it = 0; it < 8; it++) begin
            do_reload();
            stim.delete();
            for (int i = 0; i < int'($urandom_range(1, 20)); i++) stim.push_back(6'($urandom));
            load_stim("rand");
            tries = 0;
            while (m_state != 2 && tries < 4) begin
                stim = '{6'h06};
                load_stim("rand_fix");
                tries++;
            end
            if (m_state == 2) run_check(($urandom_range(0, 1) == 1) && m_prog.size() > 1,
                                        1'b0, 1'b0);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wire_select_sequencer.md
Name: wire_select_sequencer

Overview:
- Producer of the a/b/c select triples consumed by the input-side and output-side wire selection stages.
- Loads a gate program (one select triple per step) from an AXI-Stream slave into a local program buffer.
- On `start`, replays the program one triple per cycle, with a step strobe and a last-step marker.
- The program is retained after a run, so it can be replayed without reloading.

Parameters:
- NUMBER_OF_INPUT_WIRES, 4: width of the wire bus the selects index.
- CHOICE_WIDTH, $clog2(NUMBER_OF_INPUT_WIRES): width of each select.
- PROGRAM_DEPTH, 16: maximum program steps; power of two, minimum 2.
- ADDR_WIDTH, $clog2(PROGRAM_DEPTH): program buffer address width.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset: synchronous, active-low.
- s_axis_tdata  in  3*CHOICE_WIDTH  packed {a_sel, b_sel, c_sel}, with a_sel in the MSBs.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  beat accepted when tvalid and tready are both high.
- s_axis_tlast  in  1  final step of the program.
- reload  in  1  pulse: discard the stored program and return to LOAD.
- start  in  1  pulse: replay the stored program.
- busy  out  1  high while steps are being emitted.
- step_valid  out  1  a/b/c_select hold a valid step this cycle.
- step_last  out  1  coincides with the final step_valid.
- a_select, b_select, c_select  out  CHOICE_WIDTH each  current step's selects.
- program_length  out  ADDR_WIDTH+1  number of stored steps (0 = none).
- error  out  1  sticky error; cleared only by reset or reload.

Behaviour:
- Reset values:
  - All outputs 0; state LOAD; write and read pointers 0; program_length 0.
  - Reset mid-operation discards the program and any in-progress run immediately.
- State LOAD:
  - s_axis_tready = 1.
  - Each accepted beat is written at wr_ptr; wr_ptr then increments.
  - An accepted beat with tlast: program_length <= wr_ptr+1; go to READY.
  - The PROGRAM_DEPTH-th beat accepted without tlast: set error; program_length <= PROGRAM_DEPTH; go to DRAIN.
- State DRAIN:
  - s_axis_tready = 1; beats are discarded.
  - The accepted beat with tlast goes to READY.
- State READY:
  - s_axis_tready = 0.
  - reload: go to LOAD, clear wr_ptr, program_length and error.
  - start (without reload): go to RUN with rd_ptr = 0.
  - reload and start in the same cycle: reload wins.
- State RUN:
  - The buffer has a registered read.
  - start sampled at cycle T gives step k on the outputs at cycle T+1+k, for k = 0..program_length-1.
  - busy and step_valid are high for exactly program_length consecutive cycles.
  - step_last is high with step program_length-1; the next cycle the state is READY and busy/step_valid are 0.
  - Selects hold their last value when step_valid = 0.
- Ignored inputs:
  - start in LOAD, DRAIN or RUN is ignored.
  - reload in RUN is ignored; the run always completes.
  - reload in LOAD or DRAIN restarts LOAD with cleared pointers.
- A one-beat program (tlast on the first beat) is legal: step_valid and step_last are high in the same single cycle.
- Back-to-back replay: start asserted in the cycle after step_last produces the next run with no gap beyond the one READY cycle.

Optional Feature:
- Macro WIRE_SELECT_CHECK_EN.
- Defined:
  - Each accepted beat is checked: any select >= NUMBER_OF_INPUT_WIRES, or any two of a/b/c equal, fails.
  - A failing beat is accepted but not stored: no wr_ptr increment, error set.
  - A failing beat with tlast still ends LOAD; program_length counts only stored beats.
  - If program_length is then 0, the block stays in LOAD.
- Undefined: beats are stored verbatim with no check.

Decomposition:
- Package Wires gains:
  - enum wire_seq_state_t {LOAD, DRAIN, READY, RUN};
  - constant SELECTS_PER_STEP = 3.
- Sub-module wire_select_program_ram:
  - Simple dual-port, PROGRAM_DEPTH x 3*CHOICE_WIDTH.
  - Synchronous write; registered read.
  - No reset on contents.

Test Plan (NUMBER_OF_INPUT_WIRES=4, PROGRAM_DEPTH=16, 6-bit tdata):
- Load 0x06 {0,1,2}, 0x1B {1,2,3}, 0x24 {2,1,0} with tlast on the third -> program_length=3, tready=0. Then start -> selects 0/1/2, 1/2/3, 2/1/0 on cycles T+1..T+3; step_last at T+3; busy=0 at T+4.
- Load a one-beat program 0x39 {3,2,1}, then start -> a single step_valid with step_last at T+1, selects 3/2/1.
- Send 20 beats, tlast on the 20th -> error=1, program_length=16, tready high through beat 20, then READY. A run emits only the first 16 triples.
- Assert start during a run and reload during a run -> both ignored; the run completes. Then reload and start together in READY -> LOAD, program_length=0, error=0.
- Deassert resetn at the second of 3 steps -> the next cycle has all outputs 0, state LOAD, program_length=0; a subsequent start is ignored.
- WIRE_SELECT_CHECK_EN: load 0x05 {0,1,1}, then 0x06 with tlast -> error=1, program_length=1. A run emits only 0/1/2.
